pwm_timebase_controller: RTL and testbench

PWM_TIMEBASE_CONTROLLER -- requirements
Module: pwm_timebase_controller

---
 rtl/pwm_timebase_controller.sv | 138 +++++++++++++
 tb/tb_pwm_timebase_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_timebase_controller.sv
// Shared PWM timebase: prescaled up-counter with top/wrap, period-aligned config
// reloads, drain and one-shot stop modes, and sticky interrupt flags.
module pwm_timebase_controller #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_enable,
    input  logic                      cfg_oneshot,
    input  logic [WIDTH-1:0]          cfg_top,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_update,
    input  logic [CHANNELS-1:0]       cfg_channel_enable,
    input  logic [CHANNELS-1:0]       compare_rise,
    input  logic [CHANNELS:0]         irq_clear,
    output logic [WIDTH-1:0]          counter_value,
    output logic [CHANNELS-1:0]       channel_enable,
    output logic                      period_tick,
    output logic                      running,
    output logic [CHANNELS:0]         irq_flags,
    output logic                      irq,
    output logic [1:0]                dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_counter;
    logic [WIDTH-1:0]          r_top;
    logic [PRESCALE_WIDTH-1:0] r_psc_cnt;
    logic [PRESCALE_WIDTH-1:0] r_psc;
    logic [CHANNELS-1:0]       r_chen;
    logic                      r_pending;
    logic                      r_tick;
    logic                      r_running;
    logic                      r_lock;
    logic [CHANNELS:0]         r_flags;

    logic                      w_active;
    logic                      w_advance;
    logic                      w_wrap;
    logic                      w_load;
    logic                      w_end_run;
    logic                      w_start;
    logic [CHANNELS:0]         w_flag_set;

    always_comb begin
        w_active   = (r_state != IDLE);
        w_advance  = w_active && (r_psc_cnt == r_psc);
        w_wrap     = w_advance && (r_counter >= r_top);
        // An update arriving on the wrap cycle itself is honoured at that wrap.
        w_load     = w_wrap && (r_pending || cfg_update);
        w_end_run  = w_wrap && (cfg_oneshot || ((r_state == DRAIN) && !cfg_enable));
        // After a one-shot, enable must be seen low once before a restart.
        w_start    = cfg_enable && !r_lock;
        w_flag_set = {compare_rise & {CHANNELS{w_active}}, w_wrap};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_top     <= '0;
            r_psc_cnt <= '0;
            r_psc     <= '0;
            r_chen    <= '0;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_lock    <= 1'b0;
            r_flags   <= '0;
        end else begin
            r_tick  <= w_wrap;
            r_flags <= (r_flags & ~irq_clear) | w_flag_set;
            if (!cfg_enable) begin
                r_lock <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_counter <= '0;
                    r_psc_cnt <= '0;
                    r_chen    <= '0;
                    r_pending <= 1'b0;
                    if (cfg_update || w_start) begin
                        r_top <= cfg_top;
                        r_psc <= cfg_prescale;
                    end
                    if (w_start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_chen    <= cfg_channel_enable;
                    end
                end
                default: begin
                    if (w_advance) begin
                        r_psc_cnt <= '0;
                        r_counter <= w_wrap ? '0 : r_counter + 1'b1;
                    end else begin
                        r_psc_cnt <= r_psc_cnt + 1'b1;
                    end
                    // Channel enables only move on a period boundary.
                    if (w_load) begin
                        r_top     <= cfg_top;
                        r_psc     <= cfg_prescale;
                        r_chen    <= cfg_channel_enable;
                        r_pending <= 1'b0;
                    end else if (cfg_update) begin
                        r_pending <= 1'b1;
                    end
                    if (w_end_run) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_chen    <= '0;
                        r_lock    <= cfg_oneshot && cfg_enable;
                    end else if (cfg_enable) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
            endcase
        end
    end

    assign counter_value  = r_counter;
    assign channel_enable = r_chen;
    assign period_tick    = r_tick;
    assign running        = r_running;
    assign irq_flags      = r_flags;
    assign irq            = |r_flags;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_pwm_timebase_controller.sv
// Bench for pwm_timebase_controller: directed scenarios plus random traffic, all
// cycles checked against a period/phase model of the timebase.
module tb_pwm_timebase_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic        cfg_oneshot;
    logic [15:0] cfg_top;
    logic [7:0]  cfg_prescale;
    logic        cfg_update;
    logic [3:0]  cfg_channel_enable;
    logic [3:0]  compare_rise;
    logic [4:0]  irq_clear;
    logic [15:0] counter_value;
    logic [3:0]  channel_enable;
    logic        period_tick;
    logic        running;
    logic [4:0]  irq_flags;
    logic        irq;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    pwm_timebase_controller #(.WIDTH(16), .CHANNELS(4), .PRESCALE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
        .cfg_top(cfg_top), .cfg_prescale(cfg_prescale), .cfg_update(cfg_update),
        .cfg_channel_enable(cfg_channel_enable), .compare_rise(compare_rise),
        .irq_clear(irq_clear), .counter_value(counter_value),
        .channel_enable(channel_enable), .period_tick(period_tick), .running(running),
        .irq_flags(irq_flags), .irq(irq), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the period is a clock count (m_phase);
    // the counter is that count divided by the prescale ratio.
    int         m_mode;     // 0 stopped, 1 running, 2 draining
    longint     m_phase;
    int         m_top;
    int         m_psc;
    logic [3:0] m_chen;
    bit         m_pending;
    bit         m_lock;
    bit         m_tick;
    logic [4:0] m_flags;

    task automatic model_step();
        bit         wrap;
        bit         end_run;
        logic [4:0] set;
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_top = 0; m_psc = 0; m_chen = '0;
            m_pending = 0; m_lock = 0; m_tick = 0; m_flags = '0;
            return;
        end
        wrap = 0;
        set  = {(m_mode != 0) ? compare_rise : 4'b0000, 1'b0};
        if (m_mode == 0) begin
            if (cfg_enable && !m_lock) begin
                m_mode = 1; m_phase = 0; m_pending = 0;
                m_top = int'(cfg_top); m_psc = int'(cfg_prescale); m_chen = cfg_channel_enable;
            end
            if (!cfg_enable) m_lock = 0;
        end else begin
            m_phase++;
            wrap = (m_phase == longint'(m_top + 1) * longint'(m_psc + 1));
            if (wrap) begin
                end_run = cfg_oneshot || (m_mode == 2 && !cfg_enable);
                m_phase = 0;
                if (m_pending || cfg_update) begin
                    m_top = int'(cfg_top); m_psc = int'(cfg_prescale); m_chen = cfg_channel_enable;
                    m_pending = 0;
                end
                if (end_run) begin
                    m_mode = 0;
                    m_lock = cfg_oneshot && cfg_enable;
                end else begin
                    m_mode = cfg_enable ? 1 : 2;
                    if (!cfg_enable) m_lock = 0;
                end
            end else begin
                if (cfg_update) m_pending = 1;
                m_mode = cfg_enable ? 1 : 2;
                if (!cfg_enable) m_lock = 0;
            end
        end
        set[0]  = wrap;
        m_tick  = wrap;
        m_flags = (m_flags & ~irq_clear) | set;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("counter", 32'(counter_value), (m_mode == 0) ? 32'd0 : 32'(m_phase / (m_psc + 1)));
        check("tick", 32'(period_tick), 32'(m_tick));
        check("running", 32'(running), 32'(m_mode != 0));
        check("chen", 32'(channel_enable), (m_mode == 0) ? 32'd0 : 32'(m_chen));
        check("flags", 32'(irq_flags), 32'(m_flags));
        check("irq", 32'(irq), 32'(|m_flags));
    endtask

    // One clock: model follows the edge, pulses drop, outputs checked mid-cycle.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cfg_update   = 1'b0;
        compare_rise = '0;
        irq_clear    = '0;
        check_all();
    endtask

    task automatic wait_counter(input int v);
        for (int n = 0; n < 64 && counter_value != 16'(v); n++) step();
        check("wait_cnt", 32'(counter_value), 32'(v));
    endtask

    task automatic drain_to_idle();
        cfg_enable = 1'b0;
        for (int n = 0; n < 200 && running; n++) step();
        check("drain_idle", 32'(running), 32'd0);
    endtask

    initial begin
        int last;
        rst_n = 1'b0; cfg_enable = 0; cfg_oneshot = 0; cfg_top = '0; cfg_prescale = '0;
        cfg_update = 0; cfg_channel_enable = '0; compare_rise = '0; irq_clear = '0;
        @(negedge clk);
        step();
        step();
        check("rst_counter", 32'(counter_value), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        // top=3, no prescale: 0,1,2,3,0 with a tick on the wrap
        cfg_top = 16'd3; cfg_prescale = 8'd0; cfg_channel_enable = 4'b1010; cfg_enable = 1'b1;
        step();
        check("d039_start", 32'(counter_value), 32'd0);
        check("d039_chen", 32'(channel_enable), 32'hA);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("d039_seq", 32'(counter_value), 32'(i % 4));
        end
        check("d039_tick", 32'(period_tick), 32'd1);
        check("d039_flag0", 32'(irq_flags[0]), 32'd1);
        drain_to_idle();
        irq_clear = 5'h1F;
        step();

        // top=2, prescale=2: ticks 9 clocks apart
        cfg_top = 16'd2; cfg_prescale = 8'd2; cfg_enable = 1'b1;
        last = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (period_tick) begin
                if (last >= 0) check("d040_gap", 32'(i - last), 32'd9);
                last = i;
            end
        end
        drain_to_idle();

        // top=9, shrink to 4 mid-period: takes effect after the wrap
        cfg_top = 16'd9; cfg_prescale = 8'd0; cfg_enable = 1'b1;
        step();
        wait_counter(5);
        cfg_top = 16'd4; cfg_update = 1'b1;
        step();
        for (int n = 0; n < 20 && !period_tick; n++) step();
        check("d041_wrap", 32'(period_tick), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("d041_top", 32'(counter_value), 32'd4);
        step();
        check("d041_wrap2", 32'(counter_value), 32'd0);
        check("d041_tick2", 32'(period_tick), 32'd1);
        drain_to_idle();

        // drop enable at counter 2 with top=5
        cfg_top = 16'd5; cfg_enable = 1'b1;
        step();
        wait_counter(2);
        cfg_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("d042_drain", 32'(running), 32'd1);
        end
        step();
        check("d042_tick", 32'(period_tick), 32'd1);
        check("d042_idle", 32'(running), 32'd0);
        check("d042_chen", 32'(channel_enable), 32'd0);

        // one-shot with enable held high
        cfg_oneshot = 1'b1; cfg_top = 16'd3; cfg_enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("d043_tick", 32'(period_tick), 32'd1);
        check("d043_idle", 32'(running), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("d043_stay", 32'(running), 32'd0);
        cfg_enable = 1'b0; cfg_oneshot = 1'b0;
        step();

        // set and clear on the same cycle: set wins
        cfg_top = 16'd7; cfg_enable = 1'b1;
        step();
        irq_clear = 5'h1F;
        step();
        compare_rise = 4'b0010; irq_clear = 5'b00100;
        step();
        check("d044_set", 32'(irq_flags[2]), 32'd1);
        check("d044_irq", 32'(irq), 32'd1);
        irq_clear = 5'h1F;
        step();
        check("d044_clr", 32'(irq_flags), 32'd0);

        // reset just before a wrap: no tick survives
        wait_counter(7);
        rst_n = 1'b0;
        step();
        check("rst_mid_tick", 32'(period_tick), 32'd0);
        check("rst_mid_run", 32'(running), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 39) == 0) cfg_oneshot = ~cfg_oneshot;
            cfg_top            = 16'($urandom_range(0, 6));
            cfg_prescale       = 8'($urandom_range(0, 3));
            cfg_update         = ($urandom_range(0, 7) == 0);
            cfg_channel_enable = 4'($urandom_range(0, 15));
            compare_rise       = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            irq_clear          = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
